div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Iterative 32-bit integer divider; responder side of the MEM-stage div request/response handshake.
//  Accepts one DIV.W/DIV.WU/MOD.W/MOD.WU request and runs one restoring-division step per cycle.
//  Returns quotient and remainder together. MEM selects between them by op and drains via resp_ready.
//  Instantiated once beside the multiplier; requests come from EX, responses go to MEM.
// PARAMETERS
//  WIDTH  32  operand/result width; counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  resetn     in   1      asynchronous, active-low reset
//  flush      in   1      exception/ertn flush; cancels the op in flight
//  req_valid  in   1      request offered
//  req_ready  out  1      unit can accept a request this cycle
//  req_op     in   4      one-hot: [0] div.w, [1] div.wu, [2] mod.w, [3] mod.wu
//  src1       in   WIDTH  dividend
//  src2       in   WIDTH  divisor
//  resp_valid out  1      quotient/remainder valid
//  resp_ready in   1      consumer takes the response
//  quotient   out  WIDTH  signed/unsigned quotient per op
//  remainder  out  WIDTH  signed/unsigned remainder per op
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE; resp_valid=0; quotient=remainder=0; counter=0.
//    Takes effect immediately, including mid-operation. No response is produced for the aborted op.
//  - States: IDLE -> BUSY on req accept; BUSY -> DONE after WIDTH steps; DONE -> IDLE on resp handshake
//    without a new request; DONE -> BUSY on resp handshake plus new request in the same cycle.
//  - req_ready = !flush & (IDLE | (DONE & resp_ready)). Accept = req_valid & req_ready.
//  - Signed ops (op[0]|op[2]): latch |src1| and |src2|, q_neg = src1[31]^src2[31], r_neg = src1[31].
//    Unsigned ops: latch operands as-is, with q_neg = r_neg = 0.
//  - BUSY: one restoring step per edge. Shift {rem,dividend} left by 1, trial-subtract divisor.
//    On no borrow, store the difference and set the quotient bit to 1.
//    Counter increments; on the edge where counter reaches WIDTH, go to DONE.
//  - Latency: resp_valid rises exactly WIDTH (32) clock edges after the accepting edge.
//  - Sign fix is applied when entering DONE: quotient negated if q_neg, remainder negated if r_neg.
//    quotient/remainder are registered, so there is no combinational path from src1/src2 to outputs.
//  - resp_valid = (state==DONE). While resp_valid & !resp_ready, quotient/remainder/resp_valid hold stable.
//  - Divide by zero: no trap. Result is quotient=32'hFFFF_FFFF (unsigned) or the sign-fixed all-ones
//    pattern (signed); remainder = src1. Both fall out of the restoring algorithm with no special case.
//  - Overflow: 0x8000_0000 / -1 (signed) gives quotient 0x8000_0000, remainder 0, with no special case.
//  - Flush: next state IDLE on the same edge and resp_valid=0 next cycle.
//    A request presented while flush=1 is not accepted. A response handshake in a flush cycle is discarded.
//  - Flush while IDLE: no effect. Flush and reset never produce a spurious resp_valid pulse.
//  - req_op with zero or multiple bits set: treated as unsigned. This is not checked.
// STRUCTURE
//  - Shared package (cpu_pkg): DIV_OP_* one-hot bit indices; DIV_IDLE/DIV_BUSY/DIV_DONE state encodings.
//  - One sub-module, div_step: combinational single restoring iteration.
//    Inputs: rem, dividend_msb, divisor. Outputs: next_rem, q_bit.
//  - Top level holds the FSM, counter, operand/sign registers, and the sign-fix output registers.
// TESTING
//  1. div.w 100/7 -> after 32 edges, resp_valid=1, quotient=14, remainder=2.
//     mod.w -7/2 -> quotient=0xFFFF_FFFD, remainder=0xFFFF_FFFF.
//  2. div.wu 0xFFFF_FFFF/0x10 -> quotient=0x0FFF_FFFF, remainder=0xF.
//     div.w 0x8000_0000/0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0.
//  3. Divide by zero: div.wu 1234/0 -> quotient=0xFFFF_FFFF, remainder=1234, single resp_valid pulse, no hang.
//  4. Backpressure: hold resp_ready=0 for 5 cycles in DONE -> outputs and resp_valid stable, req_ready=0.
//     Then resp_ready=1 with a new req_valid -> back-to-back accept; 2nd response 32 edges later.
//  5. flush=1 at step 10 -> IDLE next edge, resp_valid never rises, req_ready=1 the cycle after.
//     Next request then yields a correct result.
//  6. resetn=0 asynchronously at step 20 -> resp_valid and outputs 0 before the next edge.
//     After release, the first request completes in exactly 32 edges.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the divider: one-hot op bit positions, FSM state encodings
// and the op decoder used to pick signed versus unsigned division.
package cpu_pkg;

    localparam int DIV_OP_DIVW  = 0;
    localparam int DIV_OP_DIVWU = 1;
    localparam int DIV_OP_MODW  = 2;
    localparam int DIV_OP_MODWU = 3;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Only a clean one-hot div.w/mod.w is signed; malformed op vectors fall back to unsigned.
    function automatic logic div_op_signed(input logic [3:0] op);
        return (op == 4'(1 << DIV_OP_DIVW)) || (op == 4'(1 << DIV_OP_MODW));
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and keep the trial difference when it does not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // The shifted remainder needs WIDTH+1 bits; the kept difference always fits in WIDTH.
    always_comb begin
        shifted  = {rem, dividend_msb};
        q_bit    = (shifted >= {1'b0, divisor});
        next_rem = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU: one quotient bit per
// cycle on operand magnitudes, sign fix applied as the result is registered.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dvs_q;
    logic             q_neg_q, r_neg_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;

    logic             accept, last_step, signed_op, q_bit;
    logic [WIDTH-1:0] next_rem;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return cond_neg(x, x[WIDTH-1]);
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_q),
        .dividend_msb (dvd_q[WIDTH-1]),
        .divisor      (dvs_q),
        .next_rem     (next_rem),
        .q_bit        (q_bit)
    );

    assign signed_op  = div_op_signed(req_op);
    assign resp_valid = (state_q == DIV_DONE);
    assign quotient   = quotient_q;
    assign remainder  = remainder_q;

    always_comb begin
        state_d   = state_q;
        req_ready = !flush && ((state_q == DIV_IDLE) || ((state_q == DIV_DONE) && resp_ready));
        accept    = req_valid && req_ready;
        last_step = (state_q == DIV_BUSY) && (cnt_q == CNT_W'(WIDTH - 1));
        case (state_q)
            DIV_IDLE: if (accept) state_d = DIV_BUSY;
            DIV_BUSY: if (last_step) state_d = DIV_DONE;
            DIV_DONE: if (resp_ready) state_d = accept ? DIV_BUSY : DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        // Flush overrides everything, including a response handshake in the same cycle.
        if (flush) state_d = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
            end else if (state_q == DIV_BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (last_step && !flush) begin
                quotient_q  <= cond_neg({dvd_q[WIDTH-2:0], q_bit}, q_neg_q);
                remainder_q <= cond_neg(next_rem, r_neg_q);
            end
        end
    end

    // Working registers are only meaningful while BUSY, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q   <= '0;
            dvd_q   <= signed_op ? magnitude(src1) : src1;
            dvs_q   <= signed_op ? magnitude(src2) : src2;
            q_neg_q <= signed_op && (src1[WIDTH-1] ^ src2[WIDTH-1]);
            r_neg_q <= signed_op && src1[WIDTH-1];
        end else if (state_q == DIV_BUSY) begin
            rem_q <= next_rem;
            dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
        end
    end

endmodule
